// File: rtl/lcd_message_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_message_ctrl
// Function : Powers up and initialises a 4-bit HD44780-style LCD, then writes
//            a two-line message read from BRAM. Command and character bytes
//            are sent through an external timing FSM using a
//            lower/upper-nibble handshake. A refresh pulse in IDLE resends
//            the message without repeating the initialisation.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_message_ctrl #(
  parameter int unsigned PWR_WAIT   = 750000,
  parameter int unsigned INIT_WAIT0 = 205000,
  parameter int unsigned INIT_WAIT1 = 5000,
  parameter int unsigned INIT_WAIT2 = 2000,
  parameter int unsigned E_PULSE    = 12,
  parameter int unsigned CLR_WAIT   = 82000,
  parameter int unsigned MSG_BASE   = 0,
  parameter int unsigned LINE_LEN   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh,
  input  logic [7:0]  bram_data,
  input  logic        tc_send_lower,
  input  logic        tc_send_upper,
  input  logic        tc_lcd_e,
  output logic [10:0] bram_addr,
  output logic        tc_fsm_enable,
  output logic [3:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic        sf_ce0,
  output logic        busy
);

  // One shared counter covers the power-up wait, every init step and the
  // clear-display wait; size it for the largest of them.
  localparam int unsigned INIT_SPAN = E_PULSE + INIT_WAIT0 + INIT_WAIT1 + INIT_WAIT2;
  localparam int unsigned MAX_A     = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int unsigned CNT_MAX   = (MAX_A > INIT_SPAN) ? MAX_A : INIT_SPAN;
  localparam int          CW        = $clog2(CNT_MAX + 1);
  localparam int          COLW      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  typedef enum logic [3:0] {
    S_PWR   = 4'd0,
    S_INIT  = 4'd1,
    S_CMD   = 4'd2,
    S_CLRW  = 4'd3,
    S_FETCH = 4'd4,
    S_ADDR1 = 4'd5,
    S_LINE1 = 4'd6,
    S_ADDR2 = 4'd7,
    S_LINE2 = 4'd8,
    S_IDLE  = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        step_q, step_d;      // init nibble index or command index
  logic [COLW-1:0]   col_q, col_d;        // character position within a line
  logic [10:0]       addr_q, addr_d;
  logic              en_q, en_d;          // drives tc_fsm_enable
  logic              lower_q, lower_d;    // lower nibble is being presented
  logic              line2_q, line2_d;    // FETCH feeds LINE2 instead of LINE1

  logic [CW-1:0]     init_end;
  logic [7:0]        cmd_byte;
  logic [7:0]        tx_byte;
  logic              sending;

  // Last counter value of the current init step: pulse time plus its wait.
  always_comb begin
    init_end = CW'(E_PULSE + INIT_WAIT2 - 1);
    case (step_q)
      2'd0:    init_end = CW'(E_PULSE + INIT_WAIT0 - 1);
      2'd1:    init_end = CW'(E_PULSE + INIT_WAIT1 - 1);
      default: init_end = CW'(E_PULSE + INIT_WAIT2 - 1);
    endcase
  end

  // Byte currently presented to the timing FSM; characters come straight
  // from BRAM, whose address is held for the whole byte.
  always_comb begin
    cmd_byte = 8'h01;
    case (step_q)
      2'd0:    cmd_byte = 8'h28;
      2'd1:    cmd_byte = 8'h06;
      2'd2:    cmd_byte = 8'h0C;
      default: cmd_byte = 8'h01;
    endcase
    tx_byte = 8'h00;
    sending = 1'b0;
    case (state_q)
      S_CMD:   begin tx_byte = cmd_byte;  sending = 1'b1; end
      S_ADDR1: begin tx_byte = 8'h80;     sending = 1'b1; end
      S_ADDR2: begin tx_byte = 8'hC0;     sending = 1'b1; end
      S_LINE1: begin tx_byte = bram_data; sending = 1'b1; end
      S_LINE2: begin tx_byte = bram_data; sending = 1'b1; end
      default: begin tx_byte = 8'h00;     sending = 1'b0; end
    endcase
  end

  // Next-state logic: init sequencing, byte handshake and message walking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    col_d   = col_q;
    addr_d  = addr_q;
    en_d    = en_q;
    lower_d = lower_q;
    line2_d = line2_q;

    if (sending) begin
      if (!en_q) begin
        // Enable-low gap between consecutive bytes is over.
        en_d    = 1'b1;
        lower_d = 1'b0;
      end else if (tc_send_upper) begin
        // Byte complete (also when it coincides with tc_send_lower).
        en_d    = 1'b0;
        lower_d = 1'b0;
        case (state_q)
          S_CMD: begin
            if (step_q == 2'd3) begin
              state_d = S_CLRW;
              cnt_d   = '0;
              step_d  = 2'd0;
            end else begin
              step_d  = step_q + 2'd1;
            end
          end
          S_ADDR1: begin
            state_d = S_FETCH;
            line2_d = 1'b0;
          end
          S_ADDR2: begin
            state_d = S_FETCH;
            line2_d = 1'b1;
          end
          S_LINE1: begin
            addr_d = addr_q + 11'd1;
            if (col_q == COLW'(LINE_LEN - 1)) begin
              col_d   = '0;
              state_d = S_ADDR2;
            end else begin
              col_d   = col_q + COLW'(1);
              state_d = S_FETCH;
            end
          end
          default: begin
            if (col_q == COLW'(LINE_LEN - 1)) begin
              col_d   = '0;
              addr_d  = 11'(MSG_BASE);
              state_d = S_IDLE;
            end else begin
              col_d   = col_q + COLW'(1);
              addr_d  = addr_q + 11'd1;
              state_d = S_FETCH;
            end
          end
        endcase
      end else if (tc_send_lower) begin
        lower_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_PWR: begin
          if (cnt_q == CW'(PWR_WAIT - 1)) begin
            state_d = S_INIT;
            cnt_d   = '0;
            step_d  = 2'd0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_INIT: begin
          if (cnt_q == init_end) begin
            cnt_d = '0;
            if (step_q == 2'd3) begin
              state_d = S_CMD;
              step_d  = 2'd0;
              en_d    = 1'b1;
              lower_d = 1'b0;
            end else begin
              step_d  = step_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CLRW: begin
          if (cnt_q == CW'(CLR_WAIT - 1)) begin
            state_d = S_ADDR1;
            cnt_d   = '0;
            en_d    = 1'b1;
            lower_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_FETCH: begin
          // BRAM data for the held address is valid from the next cycle on.
          state_d = line2_q ? S_LINE2 : S_LINE1;
          en_d    = 1'b1;
          lower_d = 1'b0;
        end
        S_IDLE: begin
          if (refresh) begin
            state_d = S_ADDR1;
            en_d    = 1'b1;
            lower_d = 1'b0;
          end
        end
        default: state_d = S_PWR;
      endcase
    end
  end

  // State and datapath registers; reset aborts any byte in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_PWR;
      cnt_q   <= '0;
      step_q  <= 2'd0;
      col_q   <= '0;
      addr_q  <= 11'(MSG_BASE);
      en_q    <= 1'b0;
      lower_q <= 1'b0;
      line2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      lower_q <= lower_d;
      line2_q <= line2_d;
    end
  end

  // Output mux: own enable pulses during power-up/init, timing FSM after.
  always_comb begin
    lcd_data = lower_q ? tx_byte[3:0] : tx_byte[7:4];
    lcd_e    = tc_lcd_e;
    case (state_q)
      S_PWR: begin
        lcd_data = 4'h0;
        lcd_e    = 1'b0;
      end
      S_INIT: begin
        lcd_data = (step_q == 2'd3) ? 4'h2 : 4'h3;
        lcd_e    = (cnt_q < CW'(E_PULSE));
      end
      S_IDLE:  lcd_e = 1'b0;
      default: lcd_e = tc_lcd_e;
    endcase
  end

  assign lcd_rs        = (state_q == S_LINE1) || (state_q == S_LINE2);
  assign lcd_rw        = 1'b0;
  assign sf_ce0        = 1'b1;
  assign busy          = (state_q != S_IDLE);
  assign tc_fsm_enable = en_q;
  assign bram_addr     = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_message_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_message_ctrl
// Function : Randomised bench for lcd_message_ctrl. A behavioural timing-FSM
//            partner answers each enabled byte; an expected byte stream built
//            from the message rules and BRAM contents is compared against
//            the nibbles observed on the LCD bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_message_ctrl;

  localparam int unsigned T_PWR  = 20;
  localparam int unsigned T_IW   = 10;
  localparam int unsigned T_EP   = 3;
  localparam int unsigned T_CLR  = 15;
  localparam int unsigned T_LL   = 4;
  localparam int unsigned BASE_W = 2046;
  localparam int          STEP   = T_EP + T_IW;

  logic        clk = 1'b0;
  logic        reset, refresh, tc_send_lower, tc_send_upper, tc_lcd_e;
  logic [7:0]  bram_data0, bram_data1;
  logic [10:0] bram_addr0, bram_addr1;
  logic        en0, en1, rs0, rs1, rw0, rw1, e0, e1, ce0, ce1, busy0, busy1;
  logic [3:0]  d0, d1;
  logic [7:0]  mem0 [2048];
  logic [7:0]  mem1 [2048];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lcd_message_ctrl #(
    .PWR_WAIT(T_PWR), .INIT_WAIT0(T_IW), .INIT_WAIT1(T_IW), .INIT_WAIT2(T_IW),
    .E_PULSE(T_EP), .CLR_WAIT(T_CLR), .MSG_BASE(0), .LINE_LEN(T_LL)
  ) dut (
    .clk(clk), .reset(reset), .refresh(refresh), .bram_data(bram_data0),
    .tc_send_lower(tc_send_lower), .tc_send_upper(tc_send_upper), .tc_lcd_e(tc_lcd_e),
    .bram_addr(bram_addr0), .tc_fsm_enable(en0), .lcd_data(d0), .lcd_rs(rs0),
    .lcd_rw(rw0), .lcd_e(e0), .sf_ce0(ce0), .busy(busy0)
  );

  lcd_message_ctrl #(
    .PWR_WAIT(T_PWR), .INIT_WAIT0(T_IW), .INIT_WAIT1(T_IW), .INIT_WAIT2(T_IW),
    .E_PULSE(T_EP), .CLR_WAIT(T_CLR), .MSG_BASE(BASE_W), .LINE_LEN(T_LL)
  ) dut_w (
    .clk(clk), .reset(reset), .refresh(refresh), .bram_data(bram_data1),
    .tc_send_lower(tc_send_lower), .tc_send_upper(tc_send_upper), .tc_lcd_e(tc_lcd_e),
    .bram_addr(bram_addr1), .tc_fsm_enable(en1), .lcd_data(d1), .lcd_rs(rs1),
    .lcd_rw(rw1), .lcd_e(e1), .sf_ce0(ce1), .busy(busy1)
  );

  // Synchronous-read BRAM models: data follows the address by one cycle.
  always @(posedge clk) begin
    bram_data0 <= mem0[bram_addr0];
    bram_data1 <= mem1[bram_addr1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " en"},    32'(en0),   32'd0);
    chk({tag, " lcd_e"}, 32'(e0),    32'd0);
    chk({tag, " rs"},    32'(rs0),   32'd0);
    chk({tag, " data"},  32'(d0),    32'd0);
    chk({tag, " busy"},  32'(busy0), 32'd1);
    chk({tag, " rw"},    32'(rw0),   32'd0);
    chk({tag, " ce0"},   32'(ce0),   32'd1);
    chk({tag, " addr"},  32'(bram_addr0), 32'd0);
    chk({tag, " addr_w"}, 32'(bram_addr1), BASE_W);
    chk({tag, " en_w"},  32'(en1),   32'd0);
    chk({tag, " e_w"},   32'(e1),    32'd0);
  endtask

  // Power-up silence, then four self-timed init nibbles 3,3,3,2.
  task automatic check_init();
    int st;
    logic exp_e;
    for (int k = 0; k < T_PWR + 4 * STEP; k++) begin
      tc_lcd_e = 1'($urandom_range(0, 1));
      refresh  = ($urandom_range(0, 7) == 0);
      #1;
      st    = (k - int'(T_PWR)) / STEP;
      exp_e = (k >= int'(T_PWR)) && (((k - int'(T_PWR)) % STEP) < int'(T_EP));
      chk("init lcd_e",   32'(e0), 32'(exp_e));
      chk("init lcd_e_w", 32'(e1), 32'(exp_e));
      chk("init en",      32'(en0), 32'd0);
      chk("init rs",      32'(rs0), 32'd0);
      if (k >= int'(T_PWR))
        chk("init nibble", 32'(d0), (st == 3) ? 32'd2 : 32'd3);
      @(negedge clk);
    end
    refresh  = 1'b0;
    tc_lcd_e = 1'b0;
  endtask

  // Plays the timing FSM for one byte and checks both nibbles, rs, the
  // enable-low gap before the byte and the held BRAM addresses.
  task automatic do_byte(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                         input logic xrs, input int xgap, input int xa0, input int xa1,
                         input bit simul);
    int gap = 0;
    int n;
    logic [10:0] a0, a1;
    while (en0 !== 1'b1 && gap < 300) begin
      if ($urandom_range(0, 3) == 0) begin
        tc_send_upper = 1'($urandom_range(0, 1));
        tc_send_lower = ~tc_send_upper;
      end
      @(negedge clk);
      tc_send_upper = 1'b0;
      tc_send_lower = 1'b0;
      gap++;
    end
    if (en0 !== 1'b1) begin
      chk({tag, " enable timeout"}, 32'(en0), 32'd1);
      return;
    end
    if (xgap >= 0) chk({tag, " gap"}, gap, xgap);
    chk({tag, " en_w"}, 32'(en1), 32'd1);
    tc_lcd_e = 1'($urandom_range(0, 1));
    #1;
    chk({tag, " lcd_e mux"}, 32'(e0), 32'(tc_lcd_e));
    a0 = bram_addr0;
    a1 = bram_addr1;
    chk({tag, " rs"},   32'(rs0), 32'(xrs));
    chk({tag, " hi"},   32'(d0),  32'(x0[7:4]));
    chk({tag, " hi_w"}, 32'(d1),  32'(x1[7:4]));
    if (xa0 >= 0) begin
      chk({tag, " addr"},   32'(a0), xa0);
      chk({tag, " addr_w"}, 32'(a1), xa1);
    end
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      chk({tag, " hi hold"},   32'(d0), 32'(x0[7:4]));
      chk({tag, " addr hold"}, 32'(bram_addr0), 32'(a0));
    end
    if (simul) begin
      tc_send_lower = 1'b1;
      tc_send_upper = 1'b1;
      @(negedge clk);
      tc_send_lower = 1'b0;
      tc_send_upper = 1'b0;
    end else begin
      tc_send_lower = 1'b1;
      @(negedge clk);
      tc_send_lower = 1'b0;
      chk({tag, " lo"},   32'(d0), 32'(x0[3:0]));
      chk({tag, " lo_w"}, 32'(d1), 32'(x1[3:0]));
      chk({tag, " lo en"}, 32'(en0), 32'd1);
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        chk({tag, " lo hold"},   32'(d0), 32'(x0[3:0]));
        chk({tag, " addr hold"}, 32'(bram_addr1), 32'(a1));
      end
      tc_send_upper = 1'b1;
      @(negedge clk);
      tc_send_upper = 1'b0;
    end
    tc_lcd_e = 1'b0;
    chk({tag, " done en"}, 32'(en0), 32'd0);
  endtask

  // Expected stream: optional command bytes, 0x80, line 1, 0xC0, line 2.
  // Returns early (before character abort_at) when abort_at >= 0.
  task automatic run_msg(input bit full, input bit mixed, input bit poke, input int abort_at);
    logic [7:0] cmds [4];
    int i, g, a0, a1;
    cmds[0] = 8'h28; cmds[1] = 8'h06; cmds[2] = 8'h0C; cmds[3] = 8'h01;
    if (full)
      for (int c = 0; c < 4; c++)
        do_byte("cmd", cmds[c], cmds[c], 1'b0, (c == 0) ? -1 : 1, -1, -1, 1'b0);
    do_byte("addr1", 8'h80, 8'h80, 1'b0, full ? int'(T_CLR) : -1, -1, -1, 1'b0);
    for (int ln = 0; ln < 2; ln++) begin
      if (ln == 1) do_byte("addr2", 8'hC0, 8'hC0, 1'b0, 1, -1, -1, 1'b0);
      for (int c = 0; c < int'(T_LL); c++) begin
        i  = ln * int'(T_LL) + c;
        g  = 1;
        a0 = i % 2048;
        a1 = (int'(BASE_W) + i) % 2048;
        if (i == abort_at) return;
        if (poke && i == 2) begin
          refresh = 1'b1;
          @(negedge clk);
          refresh = 1'b0;
          g = -1;
        end
        do_byte("char", mem0[a0], mem1[a1], 1'b1, g, a0, a1,
                mixed && ($urandom_range(0, 2) == 0));
      end
    end
    chk("end busy",   32'(busy0), 32'd0);
    chk("end addr",   32'(bram_addr0), 32'd0);
    chk("end addr_w", 32'(bram_addr1), BASE_W);
    chk("end en",     32'(en0), 32'd0);
  endtask

  initial begin
    int w;
    logic [7:0] msg [8];
    msg[0] = "A"; msg[1] = "B"; msg[2] = "C"; msg[3] = "D";
    msg[4] = "E"; msg[5] = "F"; msg[6] = "G"; msg[7] = "H";
    reset = 1'b0; refresh = 1'b0; tc_send_lower = 1'b0; tc_send_upper = 1'b0;
    tc_lcd_e = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      mem0[a] = 8'($urandom);
      mem1[a] = 8'($urandom);
    end
    for (int a = 0; a < 8; a++) mem0[a] = msg[a];
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");

    // Full power-up, init and first message with a refresh poke in line 1.
    @(negedge clk);
    reset = 1'b1;
    check_init();
    run_msg(1'b1, 1'b0, 1'b1, -1);

    // IDLE ignores stray handshake pulses and keeps lcd_e low.
    repeat (5) begin
      tc_lcd_e      = 1'b1;
      tc_send_upper = 1'($urandom_range(0, 1));
      tc_send_lower = 1'($urandom_range(0, 1));
      #1;
      chk("idle lcd_e", 32'(e0), 32'd0);
      chk("idle busy",  32'(busy0), 32'd0);
      chk("idle en",    32'(en0), 32'd0);
      @(negedge clk);
    end
    tc_send_upper = 1'b0; tc_send_lower = 1'b0; tc_lcd_e = 1'b0;

    // Refresh with new random contents and coincident handshake pulses.
    for (int a = 0; a < 8; a++) begin
      mem0[a] = 8'($urandom);
      mem1[(int'(BASE_W) + a) % 2048] = 8'($urandom);
    end
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    run_msg(1'b0, 1'b1, 1'b0, -1);

    // Abort with reset while the second line-2 character is in flight.
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    run_msg(1'b0, 1'b0, 1'b0, int'(T_LL) + 1);
    w = 0;
    while (en0 !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort reach char", 32'(en0), 32'd1);
    tc_send_lower = 1'b1;
    @(negedge clk);
    tc_send_lower = 1'b0;
    reset    = 1'b0;
    tc_lcd_e = 1'b1;
    #1;
    check_reset("abort");
    repeat (3) begin
      tc_send_upper = 1'b1;
      @(negedge clk);
      #1;
      chk("abort hold addr", 32'(bram_addr0), 32'd0);
    end
    tc_send_upper = 1'b0;
    tc_lcd_e      = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_init();
    run_msg(1'b1, 1'b1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lcd_message_ctrl.md
LCD_MESSAGE_CTRL -- requirements
Module: lcd_message_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- PWR_WAIT, 750000, cycles from reset release to first init nibble (15 ms at 50 MHz).
- INIT_WAIT0, 205000, cycles after init nibble 0 (4.1 ms).
- INIT_WAIT1, 5000, cycles after init nibble 1 (100 us).
- INIT_WAIT2, 2000, cycles after init nibbles 2 and 3 (40 us).
- E_PULSE, 12, lcd_e high cycles for each init nibble.
- CLR_WAIT, 82000, extra cycles after the clear-display command (1.64 ms).
- MSG_BASE, 0, first BRAM address of the message.
- LINE_LEN, 16, characters per display line; the message is 2*LINE_LEN bytes.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- refresh  in  1  one-cycle pulse; resend the message (init not repeated).
- bram_data  in  8  BRAM read data, valid one cycle after bram_addr.
- tc_send_lower  in  1  timing-FSM pulse: upper nibble done, present lower nibble.
- tc_send_upper  in  1  timing-FSM pulse: byte done, including the 40 us gap.
- tc_lcd_e  in  1  lcd_e generated by the timing FSM.
- bram_addr  out  11  message read address.
- tc_fsm_enable  out  1  enable for the timing FSM.
- lcd_data  out  4  LCD DB[7:4].
- lcd_rs  out  1  0 = command, 1 = character.
- lcd_rw  out  1  constant 0.
- lcd_e  out  1  LCD enable.
- sf_ce0  out  1  constant 1; disables StrataFlash on the shared bus.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 States SHALL be PWR, INIT, CMD, CLRW, FETCH, ADDR1, LINE1, ADDR2, LINE2, IDLE.
REQ-004 PWR: count PWR_WAIT cycles, then go to INIT with step 0.
REQ-005 INIT: for steps 0-3, drive nibbles 0x3, 0x3, 0x3, 0x2 with lcd_rs=0.
- lcd_e is high for E_PULSE cycles, then low for the step wait (WAIT0, WAIT1, WAIT2, WAIT2).
- lcd_data is stable for the whole step.
- After step 3, go to CMD.
REQ-006 CMD: send 0x28, 0x06, 0x0C, 0x01 in order with lcd_rs=0, each through the timing FSM.
REQ-007 Each timing-FSM byte send SHALL follow the same handshake:
- Set the byte and assert tc_fsm_enable.
- lcd_data = byte[7:4] until tc_send_lower, then byte[3:0].
- On tc_send_upper, the byte is complete.
- tc_fsm_enable drops for at least one cycle between bytes.
REQ-008 After 0x01 completes, go to CLRW: count CLR_WAIT cycles with tc_fsm_enable=0, then go to ADDR1.
REQ-009 ADDR1 sends 0x80 with lcd_rs=0. ADDR2 sends 0xC0 with lcd_rs=0.
REQ-010 LINE1 and LINE2 each send LINE_LEN characters with lcd_rs=1.
- Character data comes from bram_data.
- Addresses are MSG_BASE..MSG_BASE+LINE_LEN-1 for LINE1, then the next LINE_LEN for LINE2.
REQ-011 bram_addr SHALL stay constant for a whole byte.
- It advances only on the tc_send_upper that ends a character.
- FETCH (1 cycle, tc_fsm_enable=0) precedes every character so bram_data is valid before enable.
REQ-012 Sequencing:
- After the last LINE1 character, go to ADDR2.
- After the last LINE2 character, go to IDLE; bram_addr returns to MSG_BASE.
REQ-013 IDLE: tc_fsm_enable=0, lcd_e=0.
- A refresh pulse goes to ADDR1 (no PWR, INIT or CLRW).
- refresh is ignored in any other state.
REQ-014 lcd_e mux: own pulse generator in PWR and INIT, tc_lcd_e in all other states.
REQ-015 Handshake pulses are acted on only while tc_fsm_enable=1.
- A simultaneous tc_send_lower and tc_send_upper counts as byte complete.
REQ-016 Address arithmetic is 11-bit and wraps modulo 2048 (MSG_BASE near 2047 wraps to 0).

Reset
REQ-017 While reset=0, outputs SHALL be:
- state PWR, counters 0, bram_addr=MSG_BASE.
- tc_fsm_enable=0, lcd_e=0, lcd_rs=0, lcd_data=0, busy=1.
- lcd_rw=0, sf_ce0=1.
REQ-018 Asserting reset mid-operation SHALL abort immediately.
- The full sequence restarts from PWR on release; no partial byte completes.

Verification (bench uses PWR_WAIT=20, INIT_WAIT*=10, E_PULSE=3, CLR_WAIT=15, LINE_LEN=4)
REQ-019 Reset release:
- lcd_e stays 0 for 20 cycles.
- Four 3-cycle lcd_e pulses follow with lcd_data 3, 3, 3, 2 and lcd_rs=0.
REQ-020 CMD handshake:
- Before tc_send_lower: lcd_data=0x2. After: 0x8.
- tc_send_upper moves to byte 0x06.
- 15 enable-low cycles follow 0x01.
REQ-021 BRAM holding "ABCDEFGH" at 0..7:
- Captured sequence is 0x80, A, B, C, D, 0xC0, E, F, G, H.
- lcd_rs=1 only on letters; busy falls after H.
REQ-022 refresh in IDLE:
- Sequence restarts at 0x80 with no init nibbles.
- refresh during LINE1 has no effect.
REQ-023 reset=0 during LINE2 character 2:
- Outputs return to reset values within the same cycle.
- Release repeats REQ-019.
REQ-024 MSG_BASE=2046: bram_addr sequence is 2046, 2047, 0, 1, ...
